bist_ctrl: RTL and testbench
============================

BIST_CTRL -- requirements
Module: bist_ctrl

Interface
REQ-001 Parameter NPAT, default 7; number of test patterns applied per session, range 1..7.
REQ-002 Parameter SIG_W, default 4; signature width, matching the signature register output.
REQ-003 Parameter GOLDEN_SIG, default 4'b0101; expected fault-free signature.
REQ-004 Port clk  in  1  rising-edge clock; the only clock.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port start  in  1  session request; sampled in IDLE only.
REQ-007 Port abort  in  1  cancels a running session.
REQ-008 Port sig_in  in  SIG_W  signature from the signature register.
REQ-009 Port tst_en  out  1  test-mode enable to the pattern generator, mux and signature register.
REQ-010 Port tst_clr  out  1  one-cycle clear to the pattern generator and signature register.
REQ-011 Port busy  out  1  high in every state except IDLE.
REQ-012 Port done  out  1  one-cycle completion pulse.
REQ-013 Port pass / fail  out  1 each  session verdict; held until the next session starts.
REQ-014 Port pat_cnt  out  3  patterns applied in the current session.
REQ-015 Port fail_cnt  out  4  failing-session count (see Configuration).

Function
REQ-016 FSM states: IDLE, INIT, RUN, CAPT, COMP; state register only, outputs decoded from registers.
REQ-017 IDLE: start=1 at an edge -> INIT; pass, fail and pat_cnt clear to 0 on that edge.
REQ-018 INIT: tst_clr=1, tst_en=0, for exactly one cycle -> RUN.
REQ-019 RUN: tst_en=1; pat_cnt increments each cycle; after NPAT cycles -> CAPT with pat_cnt=NPAT.
REQ-020 CAPT: tst_en=0 for one cycle so the signature register settles -> COMP.
REQ-021 COMP: sig_in compared with GOLDEN_SIG; on leaving, pass=(equal), fail=~(equal), done=1 for one cycle -> IDLE.
REQ-022 Latency: done high exactly NPAT+4 edges after the edge sampling start (11 for NPAT=7).
REQ-023 start while busy is ignored; start held high in IDLE after done begins a new session on the next edge.
REQ-024 abort=1 in INIT/RUN/CAPT/COMP -> IDLE on the next edge; tst_en=0, no done, pass=fail=0, fail_cnt unchanged.
REQ-025 abort and start both high in IDLE -> abort wins; stay IDLE.
REQ-026 pass and fail are never both 1.

Reset
REQ-027 reset overrides all inputs, including mid-session; next state IDLE.
REQ-028 Reset values: tst_en=0, tst_clr=0, busy=0, done=0, pass=0, fail=0, pat_cnt=0, fail_cnt=0.

Configuration
REQ-029 Macro BIST_FAIL_COUNT_EN defined: fail_cnt increments on every fail verdict and saturates at 15; cleared only by reset.
REQ-030 Macro BIST_FAIL_COUNT_EN undefined: no counter logic; fail_cnt is tied to 0.

Structure
REQ-031 Shared package bist_pkg holds the FSM state encoding, SIG_W and default GOLDEN_SIG constants.
REQ-032 One sub-module, bist_patcnt (pattern counter with terminal-count flag), instantiated once; everything else is flat.

Verification
REQ-033 Reset, then start pulse, sig_in=4'b0101 held -> tst_clr one cycle, tst_en 7 cycles, done at edge 11, pass=1, fail=0.
REQ-034 Same session with sig_in=4'b0100 -> done at edge 11, pass=0, fail=1; fail_cnt=1 with the macro defined, 0 without.
REQ-035 abort asserted during the 4th RUN cycle -> IDLE next edge, tst_en=0, no done, pass=fail=0.
REQ-036 start re-pulsed during RUN -> ignored; single done at edge 11.
REQ-037 reset asserted during CAPT -> all outputs at reset values on the next edge; new start runs a full 11-edge session.
REQ-038 16 consecutive failing sessions with the macro defined -> fail_cnt=15 (saturated), pass/fail correct each session.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST controller definitions: FSM state encoding, default signature
// width and golden signature, and counter widths.
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_RUN  = 3'd2,
        S_CAPT = 3'd3,
        S_COMP = 3'd4
    } state_t;

    localparam int SIG_W_DEF = 4;
    localparam logic [SIG_W_DEF-1:0] GOLDEN_SIG_DEF = 4'b0101;

    localparam int CNT_W  = 3;
    localparam int FCNT_W = 4;

endpackage

// File: rtl/bist_patcnt.sv
// Pattern counter for a BIST session; tc flags the final pattern cycle so the
// controller can leave RUN on that edge.
module bist_patcnt
    import bist_pkg::*;
#(
    parameter int NPAT = 7
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NPAT - 1);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/bist_ctrl.sv
// BIST session controller: INIT clears, RUN applies NPAT patterns, CAPT lets the
// signature settle, COMP issues the verdict. Optional macro: BIST_FAIL_COUNT_EN.
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int                NPAT       = 7,
    parameter int                SIG_W      = SIG_W_DEF,
    parameter logic [SIG_W-1:0]  GOLDEN_SIG = GOLDEN_SIG_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [SIG_W-1:0]  sig_in,
    output logic              tst_en,
    output logic              tst_clr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [CNT_W-1:0]  pat_cnt,
    output logic [FCNT_W-1:0] fail_cnt
);

    state_t state_q;
    state_t state_d;
    logic   launch;
    logic   verdict;
    logic   match;
    logic   last_pat;

    assign launch  = (state_q == S_IDLE) && start && !abort;
    assign verdict = (state_q == S_COMP) && !abort;
    assign match   = (sig_in == GOLDEN_SIG);

    bist_patcnt #(.NPAT(NPAT)) u_patcnt (
        .clk   (clk),
        .reset (reset),
        .clr   (launch),
        .en    ((state_q == S_RUN) && !abort),
        .cnt   (pat_cnt),
        .tc    (last_pat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        tst_en  = (state_q == S_RUN);
        tst_clr = (state_q == S_INIT);
        case (state_q)
            S_IDLE:  if (launch) state_d = S_INIT;
            S_INIT:  state_d = abort ? S_IDLE : S_RUN;
            S_RUN:   begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_pat) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT:  state_d = abort ? S_IDLE : S_COMP;
            S_COMP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Verdict is cleared at launch so an aborted session leaves pass=fail=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
            pass <= 1'b0;
            fail <= 1'b0;
        end else begin
            done <= 1'b0;
            if (launch) begin
                pass <= 1'b0;
                fail <= 1'b0;
            end else if (verdict) begin
                pass <= match;
                fail <= !match;
                done <= 1'b1;
            end
        end
    end

`ifdef BIST_FAIL_COUNT_EN
    logic [FCNT_W-1:0] fail_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fail_q <= '0;
        end else if (verdict && !match && (fail_q != {FCNT_W{1'b1}})) begin
            fail_q <= fail_q + FCNT_W'(1);
        end
    end

    assign fail_cnt = fail_q;
`else
    assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_bist_ctrl.sv
// Self-checking bench for bist_ctrl: a constant vector table, directed corner
// sequences and randomized traffic compared against a session-level model.
module tb_bist_ctrl;

    localparam int NPAT = 7;
    localparam logic [3:0] GOLD = 4'b0101;
    localparam logic [3:0] BAD  = 4'b0100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] sig_in = 4'b0000;
    logic       tst_en, tst_clr, busy, done, pass, fail;
    logic [2:0] pat_cnt;
    logic [3:0] fail_cnt;

    int nCompared = 0;
    int nMismatched = 0;

    // Model: a session is active for NPAT+3 cycles after the launching edge.
    // Cycle 1 clears, cycles 2..NPAT+1 apply patterns, the last cycle judges.
    bit         mActive = 0;
    int         mAge = 0;
    bit         mDone = 0;
    bit         mPass = 0;
    bit         mFail = 0;
    int         mPat = 0;
    int         mFailCnt = 0;

    bist_ctrl #(.NPAT(NPAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .sig_in   (sig_in),
        .tst_en   (tst_en),
        .tst_clr  (tst_clr),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .pat_cnt  (pat_cnt),
        .fail_cnt (fail_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired, actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic modelStep(input logic r, input logic s, input logic a, input logic [3:0] sg);
        if (r) begin
            mActive = 0; mAge = 0; mDone = 0; mPass = 0; mFail = 0; mPat = 0; mFailCnt = 0;
        end else if (!mActive) begin
            mDone = 0;
            if (s && !a) begin
                mActive = 1; mAge = 1; mPass = 0; mFail = 0; mPat = 0;
            end
        end else begin
            mDone = 0;
            if (a) begin
                mActive = 0;
            end else if (mAge == NPAT + 3) begin
                mActive = 0;
                mDone = 1;
                mPass = (sg == GOLD);
                mFail = (sg != GOLD);
`ifdef BIST_FAIL_COUNT_EN
                if (mFail && mFailCnt < 15) mFailCnt++;
`endif
            end else begin
                if (mAge >= 2 && mAge <= NPAT + 1) mPat++;
                mAge++;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic a, input logic [3:0] sg);
        reset = r; start = s; abort = a; sig_in = sg;
        @(posedge clk);
        modelStep(r, s, a, sg);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic checkOutput(input string name);
        logic [12:0] act;
        logic [12:0] req;
        act = {busy, tst_en, tst_clr, done, pass, fail, pat_cnt, fail_cnt};
        req = {mActive, mActive && mAge >= 2 && mAge <= NPAT + 1, mActive && mAge == 1,
               mDone, mPass, mFail, 3'(mPat), 4'(mFailCnt)};
        checkVal(name, 16'(act), 16'(req));
        checkVal({name, "_excl"}, 16'(pass & fail), 16'(0));
    endtask

    task automatic idleCycles(input int n, input logic [3:0] sg, input string name);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, sg);
            checkOutput(name);
        end
    endtask

    typedef struct {
        logic       rst, st, ab;
        logic [3:0] sig;
        logic       busy, en, clr, dn, ps, fl;
        logic [2:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic st, input logic ab,
                                input logic b, input logic en, input logic clr,
                                input logic dn, input logic ps, input logic [2:0] pc);
        vec_t v;
        v.rst = rst; v.st = st; v.ab = ab; v.sig = GOLD;
        v.busy = b; v.en = en; v.clr = clr; v.dn = dn; v.ps = ps; v.fl = 1'b0; v.pc = pc;
        return v;
    endfunction

    initial begin
        vec_t vecs[$];
        int   doneSeen;

        // Passing session; the edge that samples start is edge 1, done rises on edge 11.
        vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 3'd0));
        vecs.push_back(mk(0, 1, 0,  1, 0, 1, 0, 0, 3'd0));
        vecs.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0, 3'd0));
        for (int i = 1; i <= 6; i++) vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 3'(i)));
        vecs.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0, 3'd7));
        vecs.push_back(mk(0, 0, 0,  1, 0, 0, 0, 0, 3'd7));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 1, 1, 3'd7));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1, 3'd7));
        vecs.push_back(mk(0, 1, 1,  0, 0, 0, 0, 1, 3'd7));
        vecs.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0, 3'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].ab, vecs[i].sig);
            checkVal($sformatf("vec%0d", i),
                     16'({busy, tst_en, tst_clr, done, pass, fail, pat_cnt, fail_cnt}),
                     16'({vecs[i].busy, vecs[i].en, vecs[i].clr, vecs[i].dn,
                          vecs[i].ps, vecs[i].fl, vecs[i].pc, 4'd0}));
        end

        // Failing session from a fresh reset.
        applyStimulus(1'b1, 1'b0, 1'b0, BAD);
        applyStimulus(1'b0, 1'b1, 1'b0, BAD);
        checkOutput("fail_start");
        idleCycles(9, BAD, "fail_run");
        applyStimulus(1'b0, 1'b0, 1'b0, BAD);
        checkVal("fail_done_edge11", 16'(done), 16'(1));
        checkVal("fail_verdict", 16'({pass, fail}), 16'(2'b01));
`ifdef BIST_FAIL_COUNT_EN
        checkVal("fail_cnt_one", 16'(fail_cnt), 16'(1));
`else
        checkVal("fail_cnt_zero", 16'(fail_cnt), 16'(0));
`endif

        // Abort sampled at the edge ending the 4th RUN cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, GOLD);
        idleCycles(4, GOLD, "abort_pre");
        applyStimulus(1'b0, 1'b0, 1'b1, GOLD);
        checkVal("abort_idle", 16'({busy, tst_en, done, pass, fail}), 16'(0));
        doneSeen = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, GOLD);
            checkOutput("abort_post");
            if (done) doneSeen++;
        end
        checkVal("abort_no_done", 16'(doneSeen), 16'(0));

        // start re-pulsed while running must not restart or duplicate done.
        applyStimulus(1'b0, 1'b1, 1'b0, GOLD);
        doneSeen = 0;
        for (int e = 2; e <= 14; e++) begin
            applyStimulus(1'b0, (e == 4 || e == 6), 1'b0, GOLD);
            checkOutput("restart_ign");
            if (done) begin
                doneSeen++;
                checkVal("restart_done_edge", 16'(e), 16'(11));
            end
        end
        checkVal("restart_single_done", 16'(doneSeen), 16'(1));

        // Reset asserted while in CAPT, then a complete new session.
        applyStimulus(1'b0, 1'b1, 1'b0, GOLD);
        idleCycles(8, GOLD, "capt_pre");
        applyStimulus(1'b1, 1'b0, 1'b0, GOLD);
        checkVal("capt_reset",
                 16'({busy, tst_en, tst_clr, done, pass, fail, pat_cnt, fail_cnt}), 16'(0));
        applyStimulus(1'b0, 1'b1, 1'b0, GOLD);
        idleCycles(9, GOLD, "capt_new");
        applyStimulus(1'b0, 1'b0, 1'b0, GOLD);
        checkVal("capt_new_done", 16'({done, pass, fail}), 16'(3'b110));

        // Sixteen failing sessions back to back drive the counter to saturation.
        applyStimulus(1'b1, 1'b0, 1'b0, BAD);
        for (int s = 0; s < 16; s++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, BAD);
            idleCycles(10, BAD, "sat_run");
            checkVal($sformatf("sat_verdict%0d", s), 16'({done, pass, fail}), 16'(3'b101));
        end
`ifdef BIST_FAIL_COUNT_EN
        checkVal("sat_fail_cnt", 16'(fail_cnt), 16'(15));
`else
        checkVal("sat_fail_cnt", 16'(fail_cnt), 16'(0));
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic       r, s, a;
            logic [3:0] sg;
            r  = ($urandom_range(0, 127) == 0);
            s  = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 31) == 0);
            sg = ($urandom_range(0, 1) == 1) ? GOLD : 4'($urandom_range(0, 15));
            applyStimulus(r, s, a, sg);
            checkOutput("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
